// File: rtl/pmp_pkg.sv
// Shared types and constants for the PMP access arbiter.
package pmp_pkg;

  // Requester identity; also the encoding of the round-robin pointer.
  typedef enum logic {
    SRC_IF  = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  // Access type presented to the PMP checker.
  typedef enum logic [1:0] {
    ACC_R = 2'd0,
    ACC_W = 2'd1,
    ACC_X = 2'd2
  } acc_e;

  // Fault cause encoding seen by trap/debug logic.
  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_FETCH = 2'b01;
  localparam logic [1:0] CAUSE_LOAD  = 2'b10;
  localparam logic [1:0] CAUSE_STORE = 2'b11;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Map an access type to the cause code recorded on a denial.
  function automatic logic [1:0] cause_of(acc_e acc);
    logic [1:0] c;
    case (acc)
      ACC_X:   c = CAUSE_FETCH;
      ACC_R:   c = CAUSE_LOAD;
      ACC_W:   c = CAUSE_STORE;
      default: c = CAUSE_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pmp_rr_arbiter.sv
// Two-input round-robin selector with a last-served pointer.
// On a tie the source that was not served last wins.
module pmp_rr_arbiter
  import pmp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_if,
  input  logic req_lsu,
  input  logic advance,
  output logic sel_valid,
  output logic sel_lsu
);

  src_e last_src_reg;
  src_e sel_src;

  // Pick the winner among the currently valid requests.
  always_comb begin
    sel_valid = req_if | req_lsu;
    sel_src   = SRC_IF;
    if (req_if && req_lsu) begin
      sel_src = (last_src_reg == SRC_IF) ? SRC_LSU : SRC_IF;
    end else if (req_lsu) begin
      sel_src = SRC_LSU;
    end
    sel_lsu = (sel_src == SRC_LSU);
  end

  // Remember the last served source; LSU after reset so IF wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_src_reg <= SRC_LSU;
    end else if (advance) begin
      last_src_reg <= sel_src;
    end
  end

endmodule

// File: rtl/pmp_access_arbiter.sv
// Shares one combinational PMP checker between the IF and LSU ports.
// Each request is registered, checked for exactly one cycle, then answered.
// Also keeps a first-fault record and a saturating deny counter.
module pmp_access_arbiter
  import pmp_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  input  logic              if_rsp_ready,
  output logic              if_rsp_granted,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_we,
  output logic              lsu_rsp_valid,
  input  logic              lsu_rsp_ready,
  output logic              lsu_rsp_granted,
  output logic [ADDR_W-1:0] pmp_addr,
  output logic              pmp_read_enable,
  output logic              pmp_write_enable,
  output logic              pmp_exec_enable,
  input  logic              pmp_access_granted,
  input  logic              fault_clear,
  output logic              fault_valid,
  output logic [ADDR_W-1:0] fault_addr,
  output logic [1:0]        fault_cause,
  output logic              fault_overflow,
  output logic [CNT_W-1:0]  deny_count
);

  state_e            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  src_e              src_reg;
  acc_e              acc_reg;
  logic              result_reg;

  logic              fault_valid_reg, fault_valid_next;
  logic [ADDR_W-1:0] fault_addr_reg, fault_addr_next;
  logic [1:0]        fault_cause_reg, fault_cause_next;
  logic              fault_overflow_reg, fault_overflow_next;
  logic [CNT_W-1:0]  deny_count_reg, deny_count_next;

  logic sel_valid, sel_lsu;
  logic req_hs;
  logic check_deny;

  pmp_rr_arbiter u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_if   (if_req_valid),
    .req_lsu  (lsu_req_valid),
    .advance  (req_hs),
    .sel_valid(sel_valid),
    .sel_lsu  (sel_lsu)
  );

  // The checker address simply follows the last accepted request, so it
  // holds steady outside CHECK.
  assign pmp_addr = addr_reg;

  // FSM next state plus handshake and checker-enable outputs.
  always_comb begin
    state_next       = state_reg;
    if_req_ready     = 1'b0;
    lsu_req_ready    = 1'b0;
    if_rsp_valid     = 1'b0;
    if_rsp_granted   = 1'b0;
    lsu_rsp_valid    = 1'b0;
    lsu_rsp_granted  = 1'b0;
    pmp_read_enable  = 1'b0;
    pmp_write_enable = 1'b0;
    pmp_exec_enable  = 1'b0;
    req_hs           = 1'b0;
    case (state_reg)
      IDLE: begin
        // rst_n gating keeps ready low while reset is held.
        if (sel_valid && rst_n) begin
          if (sel_lsu) lsu_req_ready = 1'b1;
          else         if_req_ready  = 1'b1;
          req_hs     = 1'b1;
          state_next = CHECK;
        end
      end
      CHECK: begin
        pmp_read_enable  = (acc_reg == ACC_R);
        pmp_write_enable = (acc_reg == ACC_W);
        pmp_exec_enable  = (acc_reg == ACC_X);
        state_next       = RESP;
      end
      RESP: begin
        if (src_reg == SRC_IF) begin
          if_rsp_valid   = 1'b1;
          if_rsp_granted = result_reg;
          if (if_rsp_ready) state_next = IDLE;
        end else begin
          lsu_rsp_valid   = 1'b1;
          lsu_rsp_granted = result_reg;
          if (lsu_rsp_ready) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Fault record update: a clear takes effect first, so a denial in the
  // same cycle is captured as a fresh first fault.
  always_comb begin
    check_deny          = (state_reg == CHECK) && !pmp_access_granted;
    fault_valid_next    = fault_valid_reg;
    fault_addr_next     = fault_addr_reg;
    fault_cause_next    = fault_cause_reg;
    fault_overflow_next = fault_overflow_reg;
    if (fault_clear) begin
      fault_valid_next    = 1'b0;
      fault_addr_next     = '0;
      fault_cause_next    = CAUSE_NONE;
      fault_overflow_next = 1'b0;
    end
    if (check_deny) begin
      if (!fault_valid_next) begin
        fault_valid_next = 1'b1;
        fault_addr_next  = addr_reg;
        fault_cause_next = cause_of(acc_reg);
      end else begin
        fault_overflow_next = 1'b1;
      end
    end
    deny_count_next = deny_count_reg;
    if (check_deny && (deny_count_reg != '1)) begin
      deny_count_next = deny_count_reg + CNT_W'(1);
    end
  end

  // State, request capture, check result and fault record registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= IDLE;
      addr_reg           <= '0;
      src_reg            <= SRC_IF;
      acc_reg            <= ACC_R;
      result_reg         <= 1'b0;
      fault_valid_reg    <= 1'b0;
      fault_addr_reg     <= '0;
      fault_cause_reg    <= CAUSE_NONE;
      fault_overflow_reg <= 1'b0;
      deny_count_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (req_hs) begin
        addr_reg <= sel_lsu ? lsu_req_addr : if_req_addr;
        src_reg  <= sel_lsu ? SRC_LSU : SRC_IF;
        acc_reg  <= sel_lsu ? (lsu_req_we ? ACC_W : ACC_R) : ACC_X;
      end
      if (state_reg == CHECK) begin
        result_reg <= pmp_access_granted;
      end
      fault_valid_reg    <= fault_valid_next;
      fault_addr_reg     <= fault_addr_next;
      fault_cause_reg    <= fault_cause_next;
      fault_overflow_reg <= fault_overflow_next;
      deny_count_reg     <= deny_count_next;
    end
  end

  assign fault_valid    = fault_valid_reg;
  assign fault_addr     = fault_addr_reg;
  assign fault_cause    = fault_cause_reg;
  assign fault_overflow = fault_overflow_reg;
  assign deny_count     = deny_count_reg;

endmodule

// File: tb/tb_pmp_access_arbiter.sv
// Directed bench for pmp_access_arbiter with a small PMP checker model:
// 0x00-0x3F RWX, 0x40-0x7F RX, 0x80-0xFF no access.
module tb_pmp_access_arbiter;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              rst_n;
  logic              if_req_valid, if_req_ready;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_rsp_valid, if_rsp_ready, if_rsp_granted;
  logic              lsu_req_valid, lsu_req_ready;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic              lsu_req_we;
  logic              lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_granted;
  logic [ADDR_W-1:0] pmp_addr;
  logic              pmp_read_enable, pmp_write_enable, pmp_exec_enable;
  logic              pmp_access_granted;
  logic              fault_clear, fault_valid, fault_overflow;
  logic [ADDR_W-1:0] fault_addr;
  logic [1:0]        fault_cause;
  logic [CNT_W-1:0]  deny_count;

  int total = 0;
  int bad   = 0;

  pmp_access_arbiter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_granted(if_rsp_granted),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_we(lsu_req_we),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_granted(lsu_rsp_granted),
    .pmp_addr(pmp_addr), .pmp_read_enable(pmp_read_enable), .pmp_write_enable(pmp_write_enable),
    .pmp_exec_enable(pmp_exec_enable), .pmp_access_granted(pmp_access_granted),
    .fault_clear(fault_clear), .fault_valid(fault_valid), .fault_addr(fault_addr),
    .fault_cause(fault_cause), .fault_overflow(fault_overflow), .deny_count(deny_count)
  );

  // Checker model: region permissions by address.
  always_comb begin
    if (pmp_addr < 8'h40)      pmp_access_granted = 1'b1;
    else if (pmp_addr < 8'h80) pmp_access_granted = !pmp_write_enable;
    else                       pmp_access_granted = 1'b0;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction; entered and left at posedge+1 with the FSM in IDLE.
  task automatic txn(input bit lsu, input logic [7:0] a, input bit we,
                     input bit clr_in_check, output logic g);
    int w;
    if (lsu) begin
      lsu_req_valid = 1'b1; lsu_req_addr = a; lsu_req_we = we;
    end else begin
      if_req_valid = 1'b1; if_req_addr = a;
    end
    #1;
    w = 0;
    while (!(lsu ? lsu_req_ready : if_req_ready) && w < 20) begin
      @(posedge clk); #2; w++;
    end
    chk("req_ready", lsu ? lsu_req_ready : if_req_ready, 1);
    @(posedge clk); #1;
    if_req_valid = 1'b0; lsu_req_valid = 1'b0;
    if (clr_in_check) fault_clear = 1'b1;
    #1;
    chk("check_enables", {pmp_read_enable, pmp_write_enable, pmp_exec_enable},
        lsu ? (we ? 3'b010 : 3'b100) : 3'b001);
    chk("check_addr", pmp_addr, a);
    chk("check_no_rsp", lsu ? lsu_rsp_valid : if_rsp_valid, 0);
    @(posedge clk); #1;
    fault_clear = 1'b0;
    chk("rsp_valid", lsu ? lsu_rsp_valid : if_rsp_valid, 1);
    chk("rsp_enables_off", {pmp_read_enable, pmp_write_enable, pmp_exec_enable}, 0);
    g = lsu ? lsu_rsp_granted : if_rsp_granted;
    if (lsu) lsu_rsp_ready = 1'b1; else if_rsp_ready = 1'b1;
    @(posedge clk); #1;
    lsu_rsp_ready = 1'b0; if_rsp_ready = 1'b0;
    $display("txn src=%s addr=0x%02h we=%0d granted=%0d deny_count=%0d",
             lsu ? "LSU" : "IF", a, we, g, deny_count);
  endtask

  initial begin
    logic g;
    int   w;
    rst_n = 1'b0;
    if_req_valid = 0; if_req_addr = 0; if_rsp_ready = 0;
    lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_we = 0; lsu_rsp_ready = 0;
    fault_clear = 0;

    // Reset state
    #12;
    chk("rst_ready", {if_req_ready, lsu_req_ready}, 0);
    chk("rst_rsp", {if_rsp_valid, if_rsp_granted, lsu_rsp_valid, lsu_rsp_granted}, 0);
    chk("rst_pmp", {pmp_addr, pmp_read_enable, pmp_write_enable, pmp_exec_enable}, 0);
    chk("rst_fault", {fault_valid, fault_addr, fault_cause, fault_overflow}, 0);
    chk("rst_count", deny_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single IF fetch, allowed
    txn(1'b0, 8'h10, 1'b0, 1'b0, g);
    chk("if_granted", g, 1);
    chk("if_fault_valid", fault_valid, 0);

    // LSU store into RX region, denied
    txn(1'b1, 8'h50, 1'b1, 1'b0, g);
    chk("st_granted", g, 0);
    chk("st_fault_valid", fault_valid, 1);
    chk("st_fault_addr", fault_addr, 8'h50);
    chk("st_fault_cause", fault_cause, 2'b11);
    chk("st_deny_count", deny_count, 1);

    // Both valid continuously: grants alternate starting with IF
    if_req_valid = 1; if_req_addr = 8'h20;
    lsu_req_valid = 1; lsu_req_addr = 8'h30; lsu_req_we = 0;
    if_rsp_ready = 1; lsu_rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      w = 0;
      while (!(if_req_ready || lsu_req_ready) && w < 10) begin
        @(posedge clk); #2; w++;
      end
      chk("rr_grant", {if_req_ready, lsu_req_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
      $display("rr grant %0d if_ready=%0d lsu_ready=%0d", k, if_req_ready, lsu_req_ready);
      @(posedge clk); #1;
    end
    if_req_valid = 0; lsu_req_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    if_rsp_ready = 0; lsu_rsp_ready = 0;
    chk("rr_count_unchanged", deny_count, 1);

    // Clear the record, then two denials without clear
    fault_clear = 1;
    @(posedge clk); #1;
    fault_clear = 0;
    chk("clr_fault", {fault_valid, fault_addr, fault_cause, fault_overflow}, 0);
    chk("clr_keeps_count", deny_count, 1);
    txn(1'b0, 8'h90, 1'b0, 1'b0, g);
    chk("d1_granted", g, 0);
    chk("d1_count", deny_count, 2);
    txn(1'b1, 8'hA0, 1'b0, 1'b0, g);
    chk("d2_granted", g, 0);
    chk("d2_fault_addr", fault_addr, 8'h90);
    chk("d2_fault_cause", fault_cause, 2'b01);
    chk("d2_overflow", fault_overflow, 1);
    chk("d2_count", deny_count, 3);

    // Clear coincident with a third denial
    txn(1'b1, 8'hC0, 1'b1, 1'b1, g);
    chk("d3_fault_addr", fault_addr, 8'hC0);
    chk("d3_fault_cause", fault_cause, 2'b11);
    chk("d3_fault_valid", fault_valid, 1);
    chk("d3_overflow", fault_overflow, 0);
    chk("d3_count_sat", deny_count, 3);

    // Fifth denial: counter stays saturated, overflow set again
    txn(1'b0, 8'h84, 1'b0, 1'b0, g);
    chk("d4_granted", g, 0);
    chk("d4_overflow", fault_overflow, 1);
    chk("d4_fault_addr", fault_addr, 8'hC0);
    chk("d5_count_sat", deny_count, 3);

    // Backpressure: last served was IF, so LSU wins this tie and then stalls
    if_req_valid = 1; if_req_addr = 8'h10;
    lsu_req_valid = 1; lsu_req_addr = 8'h20; lsu_req_we = 0;
    #1;
    chk("bp_lsu_wins", {if_req_ready, lsu_req_ready}, 2'b01);
    @(posedge clk); #1;
    lsu_req_valid = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_rsp_valid", lsu_rsp_valid, 1);
      chk("bp_rsp_granted", lsu_rsp_granted, 1);
      chk("bp_if_ready", if_req_ready, 0);
      @(posedge clk); #1;
    end

    // Reset in RESP drops outputs immediately
    #2;
    rst_n = 0;
    #1;
    chk("rst_rsp_drop", lsu_rsp_valid, 0);
    chk("rst_ready_drop", {if_req_ready, lsu_req_ready}, 0);
    chk("rst_fault_drop", {fault_valid, fault_overflow, deny_count}, 0);
    @(posedge clk); #1;
    lsu_req_valid = 1;
    rst_n = 1;
    #1;
    chk("post_rst_tie_if", {if_req_ready, lsu_req_ready}, 2'b10);
    @(posedge clk); #1;
    if_req_valid = 0; lsu_req_valid = 0;
    if_rsp_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    if_rsp_ready = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pmp_access_arbiter.md
Name: pmp_access_arbiter

Overview:
- Shares the single combinational PMP checker between the instruction-fetch (IF) port and the load/store (LSU) port.
- Uses valid/ready handshakes and round-robin arbitration.
- Registers each request, drives the checker for exactly one cycle, then returns a granted/denied response to the requester.
- Captures the first PMP fault (address and cause) and keeps a saturating deny counter for trap and debug logic.

Parameters:
- ADDR_W, 8: address width; must match the PMP checker address width.
- CNT_W, 8: width of the saturating deny counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req_valid  in  1  IF request valid
- if_req_ready  out  1  IF request accepted this cycle
- if_req_addr  in  ADDR_W  IF fetch address
- if_rsp_valid  out  1  IF response valid
- if_rsp_ready  in  1  IF consumes response
- if_rsp_granted  out  1  1 = fetch allowed
- lsu_req_valid  in  1  LSU request valid
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_addr  in  ADDR_W  LSU address
- lsu_req_we  in  1  1 = store (write), 0 = load (read)
- lsu_rsp_valid  out  1  LSU response valid
- lsu_rsp_ready  in  1  LSU consumes response
- lsu_rsp_granted  out  1  1 = access allowed
- pmp_addr  out  ADDR_W  to checker addr
- pmp_read_enable  out  1  to checker
- pmp_write_enable  out  1  to checker
- pmp_exec_enable  out  1  to checker
- pmp_access_granted  in  1  checker decision
- fault_clear  in  1  clears fault record
- fault_valid  out  1  sticky: a denial was recorded
- fault_addr  out  ADDR_W  address of first recorded denial
- fault_cause  out  2  01 = fetch, 10 = load, 11 = store, 00 = none
- fault_overflow  out  1  sticky: denial occurred while fault_valid was already 1
- deny_count  out  CNT_W  saturating count of denials

Behaviour:
- Reset (async, rst_n = 0): state IDLE. All outputs are 0: ready, rsp_valid, rsp_granted, pmp_* enables, pmp_addr, fault_*, deny_count. Round-robin pointer last_src = LSU, so IF wins the first tie. A reset mid-transaction discards the in-flight request and its response.
- FSM states: IDLE, CHECK, RESP.
- IDLE:
  - If exactly one of if_req_valid or lsu_req_valid is 1, that source is selected.
  - If both are 1, select the source not equal to last_src.
  - Assert the selected source's req_ready combinationally, in the same cycle, only in IDLE. The other ready stays 0.
  - On the handshake: register addr, source, and access type (IF = exec, LSU = we ? write : read); set last_src to the selected source; go to CHECK.
  - If no source is valid, remain in IDLE.
- CHECK (exactly one cycle):
  - Drive pmp_addr with the registered address.
  - Drive exactly one pmp_*_enable high, according to the registered type.
  - Register pmp_access_granted into the result.
  - Go to RESP.
  - Outside CHECK, all pmp_*_enable are 0 and pmp_addr holds its last value. This prevents the checker from reporting spurious denials.
- RESP:
  - Assert the selected source's rsp_valid with rsp_granted equal to the result. Hold both stable until that source's rsp_ready = 1.
  - On the handshake, go to IDLE.
  - Response latency: request handshake at cycle N gives rsp_valid at cycle N+2 at the earliest.
  - Next request acceptance is no earlier than one cycle after the response handshake.
- Fault capture: evaluated at the CHECK to RESP edge when the result is deny.
  - If fault_valid = 0: load fault_addr and fault_cause, set fault_valid.
  - Otherwise: set fault_overflow; fault_addr and fault_cause are unchanged.
  - deny_count increments on each denial and saturates at all-ones.
- fault_clear = 1 clears fault_valid, fault_addr, fault_cause and fault_overflow. deny_count is not cleared.
  - Clear coincident with a new denial: the new denial is recorded (clear first, then capture); fault_overflow stays 0.
- Response backpressure: rsp_ready held low stalls the arbiter in RESP indefinitely. Requests from the other source wait; no request is dropped.

Decomposition:
- Shared package pmp_pkg holds:
  - source enum (SRC_IF, SRC_LSU);
  - access-type enum (ACC_R, ACC_W, ACC_X);
  - fault_cause constants (CAUSE_NONE = 00, CAUSE_FETCH = 01, CAUSE_LOAD = 10, CAUSE_STORE = 11);
  - FSM state enum.
- One natural sub-module: pmp_rr_arbiter, a 2-input round-robin selector with a last-served pointer.
- Fault record and deny counter stay inline.

Test Plan:
- Single IF request, addr 0x10, checker allows: ready at cycle N, pmp_exec_enable = 1 only at N+1, if_rsp_valid = 1 and granted = 1 at N+2, fault_valid = 0.
- LSU store, addr 0x50 (RX region, checker denies): lsu_rsp_granted = 0, fault_valid = 1, fault_addr = 0x50, fault_cause = 11, deny_count = 1.
- Both valid every cycle: grants alternate IF, LSU, IF, LSU starting with IF after reset; no source is granted twice in a row while the other is valid.
- Two denials (IF 0x90, then LSU load 0xA0) without clear: fault_addr = 0x90, fault_cause = 01, fault_overflow = 1. Then fault_clear is asserted coincident with a third denial at 0xC0: fault_addr = 0xC0, fault_overflow = 0.
- Backpressure and reset: lsu_rsp_ready held low for 5 cycles keeps lsu_rsp_valid stable and if_req_ready = 0. Asserting rst_n = 0 in RESP drops outputs to 0 immediately; after release the next tie is granted to IF.
- Saturation: CNT_W = 2, 5 denials give deny_count = 3.
